pc_branch_ctrl: RTL

- Owns the program counter and sequences every change of fetch address in the 5-stage pipeline.
- Sources of the next fetch address:
  - sequential PC+4,
  - the EX-stage branch target produced by BranchComputation,
  - the ID-stage jump target.
- Arbitrates redirects against hazard-unit stalls and drives the IF/ID and ID/EX flush/write controls.
- Traps on misaligned targets and counts taken redirects for performance monitoring.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pc_next_sel.sv | 47 ++++
 rtl/pc_branch_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for PC sequencing
package pipe_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_JMP  = 2'd2,
        SEL_HOLD = 2'd3
    } pc_sel_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          PC_INC           = 4;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - priority selector for the next fetch address and pipeline controls
module pc_next_sel
    import pipe_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              stall,
    input  logic              branchEx,
    input  logic              zeroEx,
    input  logic [ADDR_W-1:0] branchTarget,
    input  logic              jumpId,
    input  logic [ADDR_W-1:0] jumpTarget,
    output pc_sel_e           sel,
    output logic              ifIdWrite,
    output logic              ifIdFlush,
    output logic              idExFlush,
    output logic              misalign
);

    logic takenBr;

    assign takenBr = branchEx & zeroEx;

    // A resolved branch in EX outranks everything younger: the jump in ID is wrong-path.
    always_comb begin
        sel       = SEL_SEQ;
        ifIdWrite = 1'b1;
        ifIdFlush = 1'b0;
        idExFlush = 1'b0;
        misalign  = 1'b0;
        if (takenBr) begin
            sel       = SEL_BR;
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
            misalign  = (branchTarget[1:0] != 2'b00);
        end else if (jumpId && !stall) begin
            sel       = SEL_JMP;
            ifIdFlush = 1'b1;
            misalign  = (jumpTarget[1:0] != 2'b00);
        end else if (stall) begin
            sel       = SEL_HOLD;
            ifIdWrite = 1'b0;
            idExFlush = 1'b1;
        end
    end

endmodule

// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - program counter, redirect FSM, misalign trap and taken-redirect counter
module pc_branch_ctrl
    import pipe_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              branch_ex_i,
    input  logic              zero_ex_i,
    input  logic [ADDR_W-1:0] branch_target_ex_i,
    input  logic              jump_id_i,
    input  logic [ADDR_W-1:0] jump_target_id_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              fetch_valid_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic              trap_o,
    output logic [ADDR_W-1:0] trap_pc_o,
    output logic [CNT_W-1:0]  taken_cnt_o
);

    state_e            state, stateNext;
    pc_sel_e           sel;
    logic [ADDR_W-1:0] pc, pcPlus4, nextPc, redirectTarget, trapPc;
    logic [CNT_W-1:0]  takenCnt;
    logic              trapFlag;
    logic              selWrite, selIfIdFlush, selIdExFlush, misalign;
    logic              loadPc, redirectTaken, goTrap;

    pc_next_sel #(.ADDR_W(ADDR_W)) u_sel (
        .stall        (stall_i),
        .branchEx     (branch_ex_i),
        .zeroEx       (zero_ex_i),
        .branchTarget (branch_target_ex_i),
        .jumpId       (jump_id_i),
        .jumpTarget   (jump_target_id_i),
        .sel          (sel),
        .ifIdWrite    (selWrite),
        .ifIdFlush    (selIfIdFlush),
        .idExFlush    (selIdExFlush),
        .misalign     (misalign)
    );

    assign pcPlus4        = pc + ADDR_W'(PC_INC);
    assign redirectTarget = (sel == SEL_BR) ? branch_target_ex_i : jump_target_id_i;

    always_comb begin
        case (sel)
            SEL_BR:   nextPc = branch_target_ex_i;
            SEL_JMP:  nextPc = jump_target_id_i;
            SEL_HOLD: nextPc = pc;
            default:  nextPc = pcPlus4;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext     = state;
        loadPc        = 1'b0;
        redirectTaken = 1'b0;
        goTrap        = 1'b0;
        fetch_valid_o = 1'b1;
        if_id_write_o = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        case (state)
            RUN: begin
                if_id_write_o = selWrite;
                if_id_flush_o = selIfIdFlush;
                id_ex_flush_o = selIdExFlush;
                redirectTaken = (sel == SEL_BR) || (sel == SEL_JMP);
                if (redirectTaken && misalign) begin
                    stateNext = TRAP;
                    goTrap    = 1'b1;
                end else begin
                    loadPc = (sel != SEL_HOLD);
                end
            end
            default: begin
                fetch_valid_o = 1'b0;
                if_id_write_o = 1'b0;
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end
        endcase
        // Controls must look idle while reset holds the pipeline.
        if (reset) begin
            if_id_write_o = 1'b1;
            if_id_flush_o = 1'b0;
            id_ex_flush_o = 1'b0;
            fetch_valid_o = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            trapFlag <= 1'b0;
            trapPc   <= '0;
            takenCnt <= '0;
        end else begin
            if (loadPc)
                pc <= nextPc;
            if (goTrap) begin
                trapFlag <= 1'b1;
                trapPc   <= redirectTarget;
            end
            if (redirectTaken && (takenCnt != '1))
                takenCnt <= takenCnt + CNT_W'(1);
        end
    end

    assign pc_o        = pc;
    assign pc_plus4_o  = pcPlus4;
    assign trap_o      = trapFlag;
    assign trap_pc_o   = trapPc;
    assign taken_cnt_o = takenCnt;

endmodule
